// File: rtl/adder_bist.sv
// adder_bist: exhaustive built-in self-test for a combinational WIDTH-bit adder
module adder_bist #(
  parameter int WIDTH = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  output logic [WIDTH-1:0]   x_o,
  output logic [WIDTH-1:0]   y_o,
  input  logic [WIDTH:0]     s_i,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [2*WIDTH:0]   err_count,
  output logic [WIDTH-1:0]   first_err_x,
  output logic [WIDTH-1:0]   first_err_y,
  output logic [WIDTH:0]     first_err_s,
  output logic               first_err_valid
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [WIDTH:0] sum_exp;
  logic mismatch, last;
  // reference sum and end-of-sweep detection for the pair currently driven
  always_comb begin
    sum_exp  = {1'b0, x_o} + {1'b0, y_o};
    mismatch = s_i != sum_exp;
    last     = (&x_o) & (&y_o);
  end
  // sequencer: sweep pairs x-major, score each returned sum, report on completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      x_o             <= '0;
      y_o             <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      err_count       <= '0;
      first_err_x     <= '0;
      first_err_y     <= '0;
      first_err_s     <= '0;
      first_err_valid <= 1'b0;
    end else if (state != RUN) begin
      if (start) begin
        state           <= RUN;
        x_o             <= '0;
        y_o             <= '0;
        busy            <= 1'b1;
        done            <= 1'b0;
        pass            <= 1'b0;
        err_count       <= '0;
        first_err_x     <= '0;
        first_err_y     <= '0;
        first_err_s     <= '0;
        first_err_valid <= 1'b0;
      end
    end else if (abort) begin
      state <= IDLE;
      x_o   <= '0;
      y_o   <= '0;
      busy  <= 1'b0;
    end else begin
      if (mismatch) begin
        err_count <= err_count + (2*WIDTH+1)'(1);
        if (!first_err_valid) begin
          first_err_x     <= x_o;
          first_err_y     <= y_o;
          first_err_s     <= s_i;
          first_err_valid <= 1'b1;
        end
      end
      if (last) begin
        state <= DONE;
        x_o   <= '0;
        y_o   <= '0;
        busy  <= 1'b0;
        done  <= 1'b1;
        pass  <= (err_count == '0) && !mismatch;
      end else begin
        y_o <= y_o + WIDTH'(1);
        x_o <= (&y_o) ? x_o + WIDTH'(1) : x_o;
      end
    end
  end
endmodule

// File: tb/tb_adder_bist.sv
// tb_adder_bist: directed checks of adder_bist against fault-injected adder models
module tb_adder_bist;
  localparam int W = 6;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic [W-1:0] x_o, y_o, first_err_x, first_err_y;
  logic [W:0] s_i, first_err_s;
  logic [2*W:0] err_count;
  logic busy, done, pass, first_err_valid;
  int mode = 0;
  int checks = 0;
  int failures = 0;
  int cyc;
  int seq_bad;

  always #5 clk = ~clk;

  // adder model: 0 good, 1 s[0] stuck-at-0, 2 s[6] stuck-at-0, 3 pair (37,5) returns 0
  always_comb begin
    s_i = {1'b0, x_o} + {1'b0, y_o};
    if (mode == 1) s_i[0] = 1'b0;
    if (mode == 2) s_i[W] = 1'b0;
    if (mode == 3 && x_o == 6'd37 && y_o == 6'd5) s_i = '0;
  end

  adder_bist #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .x_o(x_o), .y_o(y_o), .s_i(s_i),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_err_x(first_err_x), .first_err_y(first_err_y),
    .first_err_s(first_err_s), .first_err_valid(first_err_valid)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  // from RUN cycle 0, step until busy drops; verifies pair order on the way
  task automatic run_to_done();
    cyc = 0;
    seq_bad = 0;
    while (busy && cyc < 5000) begin
      if (x_o != W'(cyc >> W) || y_o != W'(cyc % 64)) seq_bad++;
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic check_result(input string tag, input int errs, input int fx, input int fy, input int fv);
    check({tag, "_cycles"}, cyc, 4096);
    check({tag, "_seq"}, seq_bad, 0);
    check({tag, "_done"}, {busy, done}, 2'b01);
    check({tag, "_pass"}, pass, errs == 0);
    check({tag, "_errs"}, err_count, errs);
    check({tag, "_fvalid"}, first_err_valid, fv);
    check({tag, "_fpair"}, {first_err_x, first_err_y, first_err_s}, {fx[5:0], fy[5:0], 7'd0});
    check({tag, "_xy_idle"}, {x_o, y_o}, 12'd0);
  endtask

  initial begin
    #12;
    check("reset_outs", {busy, done, pass, first_err_valid, x_o, y_o}, 0);
    check("reset_err", {err_count, first_err_x, first_err_y, first_err_s}, 0);
    @(negedge clk) rst_n = 1'b1;

    mode = 0;
    pulse_start();
    check("good_busy", busy, 1);
    run_to_done();
    check_result("good", 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    check("done_hold", {done, pass, busy}, 3'b110);

    mode = 1;
    pulse_start();
    run_to_done();
    check_result("s0", 2048, 0, 1, 1);

    mode = 2;
    pulse_start();
    run_to_done();
    check_result("s6", 2016, 1, 63, 1);

    mode = 3;
    pulse_start();
    run_to_done();
    check_result("pair", 1, 37, 5, 1);
    pulse_start();
    check("restart_clear", {busy, done, pass, first_err_valid, err_count}, {4'b1000, 13'd0});
    run_to_done();
    check_result("pair2", 1, 37, 5, 1);

    mode = 1;
    pulse_start();
    repeat (50) @(negedge clk);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (49) @(negedge clk);
    check("pre_abort_xy", {x_o, y_o}, {6'd1, 6'd36});
    abort = 1'b1;
    @(negedge clk) abort = 1'b0;
    check("abort_state", {busy, done, pass, x_o, y_o}, 0);
    check("abort_errs", err_count, 50);
    check("abort_first", {first_err_valid, first_err_x, first_err_y, first_err_s}, {1'b1, 6'd0, 6'd1, 7'd0});
    abort = 1'b1;
    @(negedge clk) abort = 1'b0;
    check("abort_idle_ignored", {busy, done, err_count}, {2'b00, 13'd50});

    mode = 0;
    pulse_start();
    repeat (2000) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset", {busy, done, pass, first_err_valid, x_o, y_o, err_count}, 0);
    @(negedge clk) rst_n = 1'b1;
    pulse_start();
    run_to_done();
    check_result("after_reset", 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/adder_bist.md
Name: adder_bist

Overview:
- Built-in self-test engine for the combinational 6-bit adder. It is the initiator side of the adder's x/y→s interface and the hardware counterpart of the simulation bench.
- On `start`, it drives every (x, y) operand pair exhaustively, x outer loop and y inner loop, 4096 pairs at WIDTH=6.
- Each cycle it compares the adder's returned sum against an internally computed x+y.
- It counts mismatches, captures the first failing pair, and reports pass/fail when complete.

Parameters:
- WIDTH, 6, operand width. The sum is WIDTH+1 bits and the pair space is 2^(2*WIDTH).

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  reset, asynchronous, active-low
- start  input  1  begin a test run; sampled only in IDLE or DONE
- abort  input  1  stop a run in progress; sampled only in RUN
- x_o  output  WIDTH  operand x to the adder
- y_o  output  WIDTH  operand y to the adder
- s_i  input  WIDTH+1  sum returned by the adder (combinational from x_o, y_o)
- busy  output  1  high while in RUN
- done  output  1  high while in DONE
- pass  output  1  high in DONE when err_count==0
- err_count  output  2*WIDTH+1  number of mismatching pairs in the current/last run
- first_err_x  output  WIDTH  x of the first mismatch
- first_err_y  output  WIDTH  y of the first mismatch
- first_err_s  output  WIDTH+1  s_i observed at the first mismatch
- first_err_valid  output  1  a first mismatch has been captured

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - x_o, y_o, err_count, first_err_* all 0.
  - busy, done, pass, first_err_valid all 0.
- All outputs are registered.
- States are IDLE, RUN, DONE.
- IDLE:
  - start=1 at an edge → RUN.
  - On that edge: x_o=0, y_o=0, err_count=0, first_err_* cleared, first_err_valid=0, busy=1.
- RUN, every edge:
  - Compare s_i with the zero-extended {1'b0,x_o}+{1'b0,y_o}, a full WIDTH+1-bit compare. x_o/y_o have been stable the whole cycle, so the adder settles within one cycle.
  - On mismatch, err_count increments. If first_err_valid=0, capture x_o, y_o, s_i into first_err_* and set first_err_valid=1.
  - Advance the pair index: y_o increments; when y_o wraps from 2^WIDTH-1 to 0, x_o increments.
  - After comparing pair (2^WIDTH-1, 2^WIDTH-1), go to DONE instead of advancing.
- Pair ordering and duration:
  - The pair at RUN cycle k (k from 0) is x=k>>WIDTH, y=k mod 2^WIDTH.
  - busy is high for exactly 2^(2*WIDTH) cycles (4096 at WIDTH=6).
- err_count width: 2*WIDTH+1 bits holds the maximum of 2^(2*WIDTH) errors, so no saturation is needed.
- RUN→DONE edge:
  - busy=0, done=1.
  - pass = (final err_count==0), including the comparison made on that same edge.
  - x_o=0, y_o=0.
- DONE:
  - Results are held.
  - start=1 → RUN with the same clearing as from IDLE; done/pass drop on that edge.
  - There is no other exit except reset.
- abort=1 in RUN:
  - Go to IDLE on that edge. No comparison is recorded for the current pair.
  - busy=0, done=0, pass=0, x_o=y_o=0.
  - err_count and first_err_* keep their partial values.
- start while in RUN is ignored.
- abort outside RUN is ignored.
- If start and abort are both high in RUN, abort wins.
- Reset mid-run returns immediately to the reset state; no partial result is retained.

Test Plan:
- Correct adder, pulse start: busy high exactly 4096 cycles → done=1, pass=1, err_count=0, first_err_valid=0; x_o/y_o sequence is 0/0, 0/1 … 0/63, 1/0 … 63/63.
- Adder with s[0] stuck-at-0 → err_count=2048, pass=0, first_err=(x=0, y=1, s=0000000).
- Adder with s[6] stuck-at-0 → err_count=2016, first_err=(x=1, y=63, s=0000000).
- Fault on a single pair x=37, y=5 (returns 0) → err_count=1, first_err=(37, 5, 0000000); start again from DONE clears it and repeats the same result.
- Abort after 100 RUN cycles with s[0] stuck-at-0 → IDLE, busy=0, done=0, err_count=50; start while busy is ignored (the run length is not reset).
- rst_n low mid-run (cycle 2000) → all outputs 0 immediately (asynchronously); a fresh start completes normally in 4096 cycles.
